word_serial_adder_seq: RTL and testbench
========================================

Name: word_serial_adder_seq

Overview:
- Sequencer that adds two wide operands (SIZE*WORDS bits) one SIZE-bit word per cycle.
- Drives an external SIZE-bit ripple-carry adder through its add_* ports and consumes that adder's S/Cout.
- Registers the inter-word carry between cycles.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- SIZE, 4, width of the attached adder slice; must be >= 1.
- WORDS, 4, number of SIZE-bit words per operand; must be >= 1.
- W = SIZE*WORDS is derived (localparam), not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_cin  input  1  carry-in to word 0.
- add_a  output  SIZE  current word of A to the adder.
- add_b  output  SIZE  current word of B to the adder.
- add_cin  output  1  registered carry to the adder.
- add_s  input  SIZE  adder sum.
- add_cout  input  SIZE  adder per-bit carry vector; only bit SIZE-1 is used.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result sum.
- cout  output  1  carry out of word WORDS-1.

Behaviour:
- Reset (rst=1 at a clk edge) gives: state=IDLE, out_valid=0, sum=0, cout=0, count=0, carry reg=0.
- in_ready is decoded from state: 1 in IDLE.
- Operand and sum shift registers are cleared on reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; add_a/add_b/add_cin=0.
  - On in_valid&in_ready: capture op_a, op_b into shift regs, carry<=op_cin, count<=0, go to RUN.
- RUN:
  - in_ready=0.
  - add_a=a_sh[SIZE-1:0], add_b=b_sh[SIZE-1:0], add_cin=carry.
  - Each cycle:
    - sum_sh <= {add_s, sum_sh[W-1:SIZE]}, i.e. shift right by SIZE, inserting at the top.
    - carry <= add_cout[SIZE-1].
    - a_sh/b_sh shift right by SIZE.
    - count++.
  - When count==WORDS-1, the final word is captured that cycle and the state goes to DONE. cout takes that cycle's add_cout[SIZE-1].
  - The adder is treated as purely combinational: zero-latency path add_* -> add_s/add_cout.
- DONE:
  - out_valid=1; sum and cout held stable.
  - add_a/add_b/add_cin=0.
  - On out_ready=1: go to IDLE, out_valid=0 next cycle.
- Arithmetic: {cout,sum} = op_a + op_b + op_cin, exact, W+1 bits. No overflow flag.
- Latency: operand accepted at edge t; out_valid=1 from edge t+WORDS.
- Throughput without the optional feature: one operation per WORDS+2 cycles minimum.
- WORDS=1: RUN lasts exactly one cycle; count width is max(1, clog2(WORDS)).
- Backpressure: out_valid holds indefinitely while out_ready=0; sum/cout do not change; in_ready stays 0.
- out_ready while not in DONE: ignored.
- in_valid while not ready: ignored, and no operand capture occurs.
- Reset mid-RUN or mid-DONE: operation discarded, no out_valid pulse. IDLE (in_ready=1) from the next cycle.
- sum/cout after the out handshake: retain their last value until the next DONE. Consumers must sample only when out_valid=1.

Optional Feature:
- Macro: WORD_SERIAL_ADDER_SEQ_B2B_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - If the out handshake and the in handshake occur in the same cycle, the new operands are captured and the state goes directly DONE->RUN (count=0, carry=op_cin).
  - out_valid=0 next cycle.
  - Sustained throughput: one operation per WORDS+1 cycles.
  - Out handshake without an in handshake -> IDLE as normal.
- Undefined: in_ready=1 only in IDLE, exactly as described in Behaviour.

Test Plan (SIZE=4, WORDS=4, a combinational ripple adder attached to add_*):
- 0x1234 + 0x4321, cin=0, out_ready=1 -> out_valid at edge t+4; sum=0x5555, cout=0; in_ready back to 1 the cycle after the out handshake.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1. Carry must propagate through all 4 words; check add_cin=1 in RUN cycles 1..3.
- 0xFFFF + 0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure: 0x8000 + 0x8000, out_ready low for 3 cycles after out_valid -> out_valid=1, sum=0x0000, cout=1 held for 3 cycles. in_ready=0 throughout; in_valid pulses ignored.
- Reset mid-RUN: apply rst at count=2 -> out_valid never rises, in_ready=1 after reset. A following 0x0F0F + 0x00F1, cin=0 yields sum=0x1000, cout=0.
- With WORD_SERIAL_ADDER_SEQ_B2B_EN: in_valid and out_ready held high with three operand pairs -> results spaced exactly 5 cycles apart, all correct. Without the macro the spacing is 6 cycles.

Source files
------------

// File: rtl/word_serial_adder_seq.sv
// ---------------------------------------------------------------------------
// word_serial_adder_seq
//
// Adds two W-bit operands (W = SIZE*WORDS) one SIZE-bit word per clock by
// driving an external combinational SIZE-bit ripple-carry adder. The carry
// between words is held in a register, so the attached adder only ever sees
// one slice at a time. The result is assembled in a shift register that
// fills from the top, least significant word first.
//
// Optional feature macro: WORD_SERIAL_ADDER_SEQ_B2B_EN
//   When defined, a new operand pair can be accepted in the same cycle the
//   previous result is consumed (DONE -> RUN directly), which saves one cycle
//   per operation under sustained traffic.
//
// Parameters:
//   SIZE   width of the attached adder slice (>= 1)
//   WORDS  number of SIZE-bit words per operand (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   block can accept operands
//   op_a/op_b  W-bit operands
//   op_cin     carry-in to word 0
//   add_a      current word of A to the adder (0 outside RUN)
//   add_b      current word of B to the adder (0 outside RUN)
//   add_cin    registered inter-word carry to the adder (0 outside RUN)
//   add_s      adder sum slice
//   add_cout   adder per-bit carry vector; only the top bit is used
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        W-bit result
//   cout       carry out of the most significant word
// ---------------------------------------------------------------------------
module word_serial_adder_seq #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE*WORDS-1:0] op_a,
  input  logic [SIZE*WORDS-1:0] op_b,
  input  logic                  op_cin,
  output logic [SIZE-1:0]       add_a,
  output logic [SIZE-1:0]       add_b,
  output logic                  add_cin,
  input  logic [SIZE-1:0]       add_s,
  input  logic [SIZE-1:0]       add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE*WORDS-1:0] sum,
  output logic                  cout
);

  localparam int W  = SIZE * WORDS;
  // A single-word build still needs a 1-bit counter to stay well formed.
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    sum_sh;
  logic            carry;
  logic            cout_r;
  logic [CW-1:0]   count;
  logic [W-1:0]    sum_next;
  logic            slice_cout;
  logic            unused_cout;

  // Only the carry out of the top bit of the slice crosses word boundaries;
  // the lower carry bits are part of the adder's interface but carry no
  // information this sequencer needs.
  assign slice_cout  = add_cout[SIZE-1];
  assign unused_cout = &{1'b0, add_cout};

  // The new sum word enters at the top and everything else moves down one
  // word, so after WORDS steps word 0 has reached the bottom. With a single
  // word there is nothing to shift, hence the separate branch.
  generate
    if (WORDS == 1) begin : g_one_word
      assign sum_next = add_s;
    end else begin : g_multi_word
      assign sum_next = {add_s, sum_sh[W-1:SIZE]};
    end
  endgenerate

  // The adder inputs are forced to zero outside RUN so the external adder
  // sees a quiet, defined stimulus while the block is idle or holding.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_sh[SIZE-1:0];
      add_b   = b_sh[SIZE-1:0];
      add_cin = carry;
    end
  end

  // in_ready is a pure decode of the state. With back-to-back enabled the
  // block can also take operands in DONE, but only when the current result
  // is leaving in the same cycle.
`ifdef WORD_SERIAL_ADDER_SEQ_B2B_EN
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  assign sum  = sum_sh;
  assign cout = cout_r;

  // Main sequencer. IDLE captures operands, RUN walks the words through the
  // external adder one per cycle, DONE holds the result until the consumer
  // takes it. cout is registered only on the final word so it stays stable
  // in DONE and afterwards until the next result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cout_r    <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= op_cin;
            count <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          sum_sh <= sum_next;
          carry  <= slice_cout;
          a_sh   <= a_sh >> SIZE;
          b_sh   <= b_sh >> SIZE;
          count  <= count + 1'b1;
          if (count == LAST) begin
            cout_r    <= slice_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef WORD_SERIAL_ADDER_SEQ_B2B_EN
            // Result leaves and new operands arrive in the same cycle:
            // skip IDLE entirely.
            if (in_valid) begin
              a_sh  <= op_a;
              b_sh  <= op_b;
              carry <= op_cin;
              count <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serial_adder_seq.sv
// ---------------------------------------------------------------------------
// tb_word_serial_adder_seq
//
// Self-checking bench for word_serial_adder_seq with SIZE=4, WORDS=4. A
// behavioural ripple-carry adder is attached to the add_* ports. Expected
// results go into a scoreboard queue when the operands are accepted and are
// popped by a monitor when the result handshake happens.
// ---------------------------------------------------------------------------
module tb_word_serial_adder_seq;

  localparam int SIZE  = 4;
  localparam int WORDS = 4;
  localparam int W     = SIZE * WORDS;
`ifdef WORD_SERIAL_ADDER_SEQ_B2B_EN
  localparam int SPACING = WORDS + 1;
`else
  localparam int SPACING = WORDS + 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            op_cin;
  logic [SIZE-1:0] add_a;
  logic [SIZE-1:0] add_b;
  logic            add_cin;
  logic [SIZE-1:0] add_s;
  logic [SIZE-1:0] add_cout;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    sum;
  logic            cout;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int nPopped     = 0;

  logic [W:0] sbq[$];
  int         outCyc[$];
  logic [W:0] expv;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[8];

  word_serial_adder_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural combinational ripple adder standing in for the external slice.
  function automatic logic [2*SIZE-1:0] ripple(input logic [SIZE-1:0] a,
                                               input logic [SIZE-1:0] b,
                                               input logic ci);
    logic [SIZE-1:0] s;
    logic [SIZE-1:0] co;
    logic c;
    c = ci;
    for (int i = 0; i < SIZE; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      co[i] = c;
    end
    return {co, s};
  endfunction

  assign {add_cout, add_s} = ripple(add_a, add_b, add_cin);

  // Carry expected into word k: carry out of the lower k words plus cin.
  function automatic logic carryInto(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input int k);
    logic [W:0] m;
    logic [W:0] s;
    m = ((W+1)'(1) << (SIZE * k)) - (W+1)'(1);
    s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, cin};
    return s[SIZE * k];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic failNote(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Result monitor: pops the scoreboard when the output handshake is seen.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        failNote("unexpected_result");
      end else begin
        expv = sbq.pop_front();
        checkOutput("result_sum", 64'(sum), 64'(expv[W-1:0]));
        checkOutput("result_cout", 64'(cout), 64'(expv[W]));
      end
      outCyc.push_back(cyc);
      nPopped++;
    end
  end

  // Drives one operand pair, waits (bounded) for acceptance, pushes the
  // expected result. Returns just after the accepting edge with in_valid high.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic [W-1:0] es,
                               input logic ec);
    bit ok;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNote("accept_timeout");
    else sbq.push_back({ec, es});
    @(posedge clk);
    #1;
  endtask

  // One full operation with out_ready high, checking every RUN cycle's adder
  // drive, the latency to out_valid, and the return to IDLE.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] es, input logic ec);
    out_ready = 1'b1;
    applyStimulus(a, b, cin, es, ec);
    in_valid = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      checkOutput($sformatf("run%0d_out_valid", k), 64'(out_valid), 64'd0);
      checkOutput($sformatf("run%0d_in_ready", k), 64'(in_ready), 64'd0);
      checkOutput($sformatf("run%0d_add_a", k), 64'(add_a), 64'((a >> (SIZE*k)) & 16'hF));
      checkOutput($sformatf("run%0d_add_b", k), 64'(add_b), 64'((b >> (SIZE*k)) & 16'hF));
      checkOutput($sformatf("run%0d_add_cin", k), 64'(add_cin), 64'(carryInto(a, b, cin, k)));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("done_out_valid", 64'(out_valid), 64'd1);
    checkOutput("done_add_a", 64'(add_a), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
    checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNote("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rs;
    bit           sawValid;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
    checkOutput("rst_add_a", 64'(add_a), 64'd0);
    checkOutput("rst_add_cin", 64'(add_cin), 64'd0);
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);
    end

    // A few random operands against the bench's own arithmetic
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      runOp(ra, rb, rc, rs[W-1:0], rs[W]);
    end

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    in_valid = 1'b0;
    repeat (WORDS) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      op_a     = 16'h1111;
      op_b     = 16'h2222;
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp%0d_sum", i), 64'(sum), 64'h0000);
      checkOutput($sformatf("bp%0d_cout", i), 64'(cout), 64'd1);
      checkOutput($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_drained", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN (count == 2)
    out_ready = 1'b1;
    applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_sum", 64'(sum), 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sawValid = sawValid | out_valid;
    end
    checkOutput("midrst_no_valid", 64'(sawValid), 64'd0);
    @(posedge clk);
    #1;
    runOp(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

    // Sustained traffic: result spacing
    outCyc.delete();
    nPopped   = 0;
    out_ready = 1'b1;
    applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    in_valid = 1'b0;
    waitDrain(100);
    repeat (2) @(negedge clk);
    checkOutput("b2b_result_count", 64'(outCyc.size()), 64'd3);
    if (outCyc.size() >= 3) begin
      checkOutput("b2b_spacing_0", 64'(outCyc[1] - outCyc[0]), 64'(SPACING));
      checkOutput("b2b_spacing_1", 64'(outCyc[2] - outCyc[1]), 64'(SPACING));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
